// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the legal width range for Gray counters.
package gray_pkg;

  localparam int unsigned GRAY_W_MIN = 2;
  localparam int unsigned GRAY_W_MAX = 16;

  // Binary to Gray: each bit XORed with its upper neighbour.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: XOR prefix running from the MSB downward.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_n_if.sv
// Control and status bundle of the Gray counter.
interface gray_counter_n_if #(
  parameter int unsigned WIDTH = 3
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadGray;
  logic             ClrFlags;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] Binary;
  logic             Overflow;
  logic             Underflow;
  logic             Tick;

  modport master (
    output En, Up, Load, LoadGray, ClrFlags,
    input  Output, Binary, Overflow, Underflow, Tick
  );

  modport slave (
    input  En, Up, Load, LoadGray, ClrFlags,
    output Output, Binary, Overflow, Underflow, Tick
  );
endinterface

// File: rtl/gray_counter_n_gray2bin.sv
// Combinational Gray-to-binary decoder, reusable by any Gray consumer.
module gray2bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Zero-extended upper bits decode to zero, so the low WIDTH bits are exact.
  assign bin = WIDTH'(gray_pkg::gray2bin(GRAY_W_MAX'(gray)));

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised Gray counter: up/down, Gray load, wrap or saturate, sticky flags.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  gray_counter_n_if.slave bus
);

  if (WIDTH < GRAY_W_MIN || WIDTH > GRAY_W_MAX) begin : g_bad_width
    $error("gray_counter_n: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tick_q, tick_d;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] load_bin;

  gray2bin #(.WIDTH(WIDTH)) u_load_dec (
    .gray (bus.LoadGray),
    .bin  (load_bin)
  );

  // Next count, end-of-range events and sticky flag update.
  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.Load) begin
      cnt_d = load_bin;
    end else if (bus.En) begin
      if (bus.Up) begin
        if (cnt_q == MAX) begin
          ovf_set = 1'b1;
          tick_d  = 1'b1;
          cnt_d   = SATURATE ? MAX : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          unf_set = 1'b1;
          tick_d  = 1'b1;
          cnt_d   = SATURATE ? '0 : MAX;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    // A set on the same edge as a clear wins.
    ovf_d  = ovf_set | (ovf_q & ~bus.ClrFlags);
    unf_d  = unf_set | (unf_q & ~bus.ClrFlags);
    gray_d = WIDTH'(bin2gray(GRAY_W_MAX'(cnt_d)));
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      tick_q <= tick_d;
    end
  end

  assign bus.Binary    = cnt_q;
  assign bus.Output    = gray_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
  assign bus.Tick      = tick_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: a wrapping 3-bit and a saturating 4-bit instance
// driven in lockstep, checked by a scoreboard plus directed end-case checks.
module tb_gray_counter_n;

  typedef struct {
    int bin;
    int gray;
    bit ovf;
    bit unf;
    bit tick;
    bit stepped;
  } exp_t;

  bit   Clk;
  logic Reset_n;

  gray_counter_n_if #(.WIDTH(3)) if3 ();
  gray_counter_n_if #(.WIDTH(4)) if4 ();

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut3 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (if3.slave)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) dut4 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (if4.slave)
  );

  initial forever #5 Clk = ~Clk;

  int   tests = 0;
  int   fails = 0;
  exp_t q3[$];
  exp_t q4[$];
  exp_t pend[2];

  // Reference model state, index 0 = 3-bit wrapping, 1 = 4-bit saturating.
  int wd[2]  = '{3, 4};
  bit sat[2] = '{1'b0, 1'b1};
  int mc[2];
  bit mo[2];
  bit mu[2];
  bit mt[2];
  int prevg[2];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one edge.
  task automatic model(input int d, input bit rst_n, input bit en, input bit up,
                       input bit ld, input int lg, input bit clr);
    int maxv;
    int g;
    bit so;
    bit su;
    maxv = (1 << wd[d]) - 1;
    so = 1'b0;
    su = 1'b0;
    if (!rst_n) begin
      mc[d] = 0; mo[d] = 1'b0; mu[d] = 1'b0; mt[d] = 1'b0;
    end else begin
      mt[d] = 1'b0;
      if (ld) begin
        g = lg & maxv;
        for (int v = 0; v <= maxv; v++) if ((v ^ (v >> 1)) == g) mc[d] = v;
      end else if (en) begin
        if (up) begin
          if (mc[d] == maxv) begin so = 1'b1; mt[d] = 1'b1; if (!sat[d]) mc[d] = 0; end
          else mc[d] = mc[d] + 1;
        end else begin
          if (mc[d] == 0) begin su = 1'b1; mt[d] = 1'b1; if (!sat[d]) mc[d] = maxv; end
          else mc[d] = mc[d] - 1;
        end
      end
      mo[d] = so | (mo[d] & !clr);
      mu[d] = su | (mu[d] & !clr);
    end
    pend[d].bin     = mc[d];
    pend[d].gray    = mc[d] ^ (mc[d] >> 1);
    pend[d].ovf     = mo[d];
    pend[d].unf     = mu[d];
    pend[d].tick    = mt[d];
    pend[d].stepped = rst_n && en && !ld;
  endtask

  // Apply one edge of stimulus to both instances and queue the expectations.
  task automatic drive(input bit rst_n, input bit en, input bit up, input bit ld,
                       input int lg, input bit clr);
    Reset_n = rst_n;
    if3.En = en; if3.Up = up; if3.Load = ld; if3.LoadGray = 3'(lg); if3.ClrFlags = clr;
    if4.En = en; if4.Up = up; if4.Load = ld; if4.LoadGray = 4'(lg); if4.ClrFlags = clr;
    model(0, rst_n, en, up, ld, lg, clr);
    model(1, rst_n, en, up, ld, lg, clr);
    @(posedge Clk);
    q3.push_back(pend[0]);
    q4.push_back(pend[1]);
    #1;
  endtask

  task automatic compare(input int d, input exp_t e, input int bin, input int gray,
                         input bit ovf, input bit unf, input bit tick);
    string p;
    p = (d == 0) ? "w3" : "w4s";
    chk({p, "_binary"}, bin, e.bin);
    chk({p, "_output"}, gray, e.gray);
    chk({p, "_overflow"}, int'(ovf), int'(e.ovf));
    chk({p, "_underflow"}, int'(unf), int'(e.unf));
    chk({p, "_tick"}, int'(tick), int'(e.tick));
    chk({p, "_gray_of_binary"}, gray, bin ^ (bin >> 1));
    if (e.stepped) chk({p, "_one_bit_step"}, int'($countones(gray ^ prevg[d]) <= 1), 1);
    prevg[d] = gray;
  endtask

  // Monitor: one expectation per edge per instance, checked mid-cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      compare(0, e, int'(if3.Binary), int'(if3.Output), if3.Overflow, if3.Underflow, if3.Tick);
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      compare(1, e, int'(if4.Binary), int'(if4.Output), if4.Overflow, if4.Underflow, if4.Tick);
    end
  end

  int gseq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};

  initial begin
    bit en, up, ld, clr, rst_n;
    int lg;

    // Reset state.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("rst_w3_output", int'(if3.Output), 0);
    chk("rst_w4_binary", int'(if4.Binary), 0);
    chk("rst_w3_tick", int'(if3.Tick), 0);

    // Full 3-bit up cycle with wrap on the 8th step.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      chk($sformatf("w3_seq_%0d", i), int'(if3.Output), gseq[i]);
      chk($sformatf("w3_seq_tick_%0d", i), int'(if3.Tick), (i == 8) ? 1 : 0);
      chk($sformatf("w3_seq_ovf_%0d", i), int'(if3.Overflow), (i == 8) ? 1 : 0);
    end

    // Saturating down from 0: holds, Tick stays high.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("w4s_sat_binary", int'(if4.Binary), 0);
      chk("w4s_sat_underflow", int'(if4.Underflow), 1);
      chk("w4s_sat_tick", int'(if4.Tick), 1);
    end

    // Load wins over En; then one up step.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 13, 1'b0);
    chk("w4s_load_binary", int'(if4.Binary), 9);
    chk("w4s_load_output", int'(if4.Output), 13);
    chk("w4s_load_flags", int'({if4.Overflow, if4.Underflow, if4.Tick}), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("w4s_after_load_binary", int'(if4.Binary), 10);
    chk("w4s_after_load_output", int'(if4.Output), 15);

    // Clear on the same edge as a wrap: set wins; a later clear works.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    chk("w3_load_max", int'(if3.Binary), 7);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    chk("w3_clr_vs_set_ovf", int'(if3.Overflow), 1);
    chk("w3_clr_vs_set_binary", int'(if3.Binary), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("w3_clr_ovf", int'(if3.Overflow), 0);
    chk("w3_clr_tick", int'(if3.Tick), 0);

    // Reset in mid-count.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("w3_mid_binary", int'(if3.Binary), 5);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      chk("mid_rst_w3_all", int'({if3.Binary, if3.Output, if3.Overflow, if3.Underflow, if3.Tick}), 0);
      chk("mid_rst_w4_all", int'({if4.Binary, if4.Output, if4.Overflow, if4.Underflow, if4.Tick}), 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(63) != 0);
      en    = ($urandom_range(3) != 0);
      up    = $urandom_range(1) == 1;
      ld    = ($urandom_range(15) == 0);
      clr   = ($urandom_range(15) == 0);
      lg    = int'($urandom_range(15));
      drive(rst_n, en, up, ld, lg, clr);
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge Clk);
    #1;
    chk("q3_drained", q3.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised synchronous Gray-code counter, successor to the fixed 3-bit Gray counter. It adds configurable width, up/down counting, parallel load of a Gray-coded value, a wrap-or-saturate mode, and separate sticky overflow/underflow flags with a software clear. All outputs are registered, so the Gray output is glitch-free for consumers in other clock domains or for display logic.

## Interface
- WIDTH, 3: counter width in bits; legal range 2..16.
- SATURATE, 0: 0 = wrap at the ends; 1 = hold at the end value.
- Clk  input  1  rising-edge clock; the block's only clock.
- Reset_n  input  1  synchronous, active-low reset; sampled on the Clk rising edge.
- En  input  1  count enable.
- Up  input  1  1 = count up; 0 = count down. Ignored when En=0.
- Load  input  1  parallel load strobe.
- LoadGray  input  WIDTH  value to load, Gray-coded.
- ClrFlags  input  1  clears Overflow and Underflow.
- Output  output  WIDTH  current count, Gray-coded, registered.
- Binary  output  WIDTH  current count, binary, registered.
- Overflow  output  1  sticky; set by an up-step from the maximum count.
- Underflow  output  1  sticky; set by a down-step from 0.
- Tick  output  1  one-cycle pulse marking an end-of-range event.

## Operation
- State: binary count `cnt` (WIDTH bits), Gray register, Overflow, Underflow, Tick.
- The Gray register is always written as (next_cnt >> 1) ^ next_cnt, in the same edge as `cnt`. Output never lags Binary.
- Priority at each rising edge, highest first:
  - Reset_n=0: cnt=0, Output=0, Binary=0, Overflow=0, Underflow=0, Tick=0.
  - Load=1: cnt = gray2bin(LoadGray). No flag is set. Tick=0. En and Up are ignored.
  - En=1, Up=1:
    - If cnt = 2^WIDTH-1 (MAX): Overflow<=1 and Tick<=1. cnt<=0 when SATURATE=0; cnt holds at MAX when SATURATE=1.
    - Otherwise cnt<=cnt+1.
  - En=1, Up=0:
    - If cnt = 0: Underflow<=1 and Tick<=1. cnt<=MAX when SATURATE=0; cnt holds at 0 when SATURATE=1.
    - Otherwise cnt<=cnt-1.
  - En=0: cnt holds. Tick<=0.
- ClrFlags=1 clears both flags. It is evaluated independently of Load and count.
  - If the same edge also sets a flag, the set wins: the flag reads 1 afterwards.
  - Reset still overrides everything.
- Flags are sticky. Only Reset_n or ClrFlags clears them.
- Arithmetic is modulo 2^WIDTH. There are no extra carry bits.
- In saturate mode, every further enabled step at the end re-asserts Tick.

## Timing
- Latency is 1 cycle from a sampled input to every output. There is no combinational input-to-output path.
- Tick is high for exactly the one cycle following the wrapping or saturating edge.
  - Back-to-back end events give a continuous high.
  - A Load or reset in the next edge drops Tick.
- Reset mid-count: outputs read 0 on the cycle after the edge where Reset_n is sampled low. The first count occurs on the first edge with Reset_n=1 and En=1.
- No initial blocks. Power-up state is undefined until the first reset edge.

## Structure
- Shared package/header `gray_pkg`:
  - constants for the WIDTH legal range;
  - bin2gray function;
  - gray2bin function (XOR prefix, MSB downward).
- One sub-module: `gray2bin #(WIDTH)`. It is purely combinational and decodes LoadGray. Instantiate it once; it can be reused by other Gray consumers.
- Top level: one clocked always block plus next-state combinational logic. Expected size is about 150–250 lines.

## Test plan
- WIDTH=3, SATURATE=0, Up=1, En held high for 8 edges after reset.
  - Output sequence: 000,001,011,010,110,111,101,100,000.
  - Overflow=1 and Tick pulses exactly on the 8th step.
- WIDTH=4, SATURATE=1, reset then Up=0, En=1 for 3 edges.
  - Binary stays 0 and Underflow=1.
  - Tick is high for 3 consecutive cycles.
- WIDTH=4, Load=1 with LoadGray=4'b1101 and En=1 in the same edge.
  - Binary=9, Output=1101, no flags set.
  - Next edge with Up=1: Binary=10, Output=1111.
- ClrFlags=1 on the same edge as an up-wrap from MAX. Overflow stays 1.
  - ClrFlags=1 on the next edge with En=0: Overflow=0.
- Reset_n=0 in mid-count (Binary=5) with En=1.
  - All outputs are 0 the following cycle and stay 0 while Reset_n=0.
- Random Up/En/Load for 10k cycles against a reference model. Check each cycle:
  - Output == Binary ^ (Binary>>1);
  - Output changes by at most 1 bit per enabled step.
